// File: rtl/lsu_subword.sv
// Load/store formatting stage in front of a word-wide, 1-cycle-read data memory.
// Optional LSU_MISALIGN_TRAP_EN: fault on misaligned/illegal requests instead of force-aligning.
module lsu_subword #(
   parameter int unsigned AW   = 10,
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            stall,
   output logic [XLEN-1:0] rdata,
   output logic            rdata_valid,
   output logic            fault,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      StIdle,
      StLoadResp,
      StRmwWrite
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      off_q;
   logic [1:0]      size_q;
   logic            uns_q;
   logic [15:0]     wdata_q;
   logic [AW-1:0]   idx_q;

   logic [1:0]      eff_size;
   logic [1:0]      eff_off;
   logic            illegal;
   logic            accept;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic [XLEN-1:0] load_ext;
   logic [XLEN-1:0] merged;

   logic unused_addr;
   assign unused_addr = ^{req_addr[XLEN-1:AW+2], req_wdata[XLEN-1:16]};

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      eff_size = req_size;
      eff_off  = req_addr[1:0];
      unique case (req_size)
         2'b00:   illegal = 1'b0;
         2'b01:   illegal = req_addr[0];
         2'b10:   illegal = (req_addr[1:0] != 2'b00);
         default: illegal = 1'b1;
      endcase
   end
`else
   // Misaligned accesses are force-aligned; size 11 behaves as a word.
   always_comb begin
      illegal = 1'b0;
      unique case (req_size)
         2'b00: begin
            eff_size = 2'b00;
            eff_off  = req_addr[1:0];
         end
         2'b01: begin
            eff_size = 2'b01;
            eff_off  = {req_addr[1], 1'b0};
         end
         default: begin
            eff_size = 2'b10;
            eff_off  = 2'b00;
         end
      endcase
   end
`endif

   assign accept = (state_q == StIdle) && req_valid && !illegal;

   always_comb begin
      byte_v = mem_rdata[{off_q, 3'b000} +: 8];
      half_v = mem_rdata[{off_q[1], 4'b0000} +: 16];
      unique case (size_q)
         2'b00:   load_ext = uns_q ? {{(XLEN-8){1'b0}}, byte_v}
                                   : {{(XLEN-8){byte_v[7]}}, byte_v};
         2'b01:   load_ext = uns_q ? {{(XLEN-16){1'b0}}, half_v}
                                   : {{(XLEN-16){half_v[15]}}, half_v};
         default: load_ext = mem_rdata;
      endcase
   end

   // Read-modify-write merge: only the addressed lane(s) change.
   always_comb begin
      merged = mem_rdata;
      if (size_q == 2'b00) begin
         merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      rdata       = '0;
      rdata_valid = 1'b0;
      fault       = 1'b0;
      mem_addr    = idx_q;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      unique case (state_q)
         StIdle: begin
            mem_addr = req_addr[AW+1:2];
            if (req_valid) begin
               if (illegal) begin
                  fault = 1'b1;
               end else if (req_we && eff_size == 2'b10) begin
                  mem_we    = 1'b1;
                  mem_wdata = req_wdata;
               end else begin
                  stall   = 1'b1;
                  state_d = req_we ? StRmwWrite : StLoadResp;
               end
            end
         end
         StLoadResp: begin
            rdata       = load_ext;
            rdata_valid = 1'b1;
            state_d     = StIdle;
         end
         StRmwWrite: begin
            mem_we    = 1'b1;
            mem_wdata = merged;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         off_q   <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            off_q   <= eff_off;
            size_q  <= eff_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata[15:0];
            idx_q   <= req_addr[AW+1:2];
         end
      end
   end

endmodule

// File: tb/tb_lsu_subword.sv
// Directed self-checking bench for lsu_subword with a registered-read word memory model.
module tb_lsu_subword;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [1:0]    req_size = 2'b00;
   logic          req_unsigned = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          stall;
   logic [31:0]   rdata;
   logic          rdata_valid;
   logic          fault;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic [31:0]   mem [0:(1<<AW)-1];
   int            wr_cnt = 0;
   int            n_pass = 0;
   int            n_total = 0;

   lsu_subword #(.AW(AW), .XLEN(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .stall        (stall),
      .rdata        (rdata),
      .rdata_valid  (rdata_valid),
      .fault        (fault),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      mem_rdata <= mem[mem_addr];
   end

   // Two-cycle load: samples cycle 0 and cycle 1; req_* is scrambled in cycle 1.
   task automatic load_op(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                          output logic st0, output logic f0, output logic v0,
                          output logic v1, output logic [31:0] rd1, output logic st1);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = '0;
      @(negedge clk);
      st0 = stall; f0 = fault; v0 = rdata_valid;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 32'h0000_0FFC; req_size = 2'b10; req_unsigned = ~uns;
      @(negedge clk);
      v1 = rdata_valid; rd1 = rdata; st1 = stall;
   endtask

   task automatic store_op(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                           output logic st0, output logic we0, output logic f0,
                           output logic [31:0] wd0, output logic [AW-1:0] ad0,
                           output logic we1, output logic st1, output logic [31:0] wd1,
                           output logic [AW-1:0] ad1);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = sz; req_unsigned = 1'b0;
      req_addr = a; req_wdata = wd;
      @(negedge clk);
      st0 = stall; we0 = mem_we; f0 = fault; wd0 = mem_wdata; ad0 = mem_addr;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0000_0FF0; req_wdata = 32'h5A5A_5A5A;
      @(negedge clk);
      we1 = mem_we; st1 = stall; wd1 = mem_wdata; ad1 = mem_addr;
   endtask

   logic          s0, w0, f0, s1, w1, v0, v1;
   logic [31:0]   d0, d1;
   logic [AW-1:0] a0, a1;
   int            wc;

   task automatic test_reset();
      @(negedge clk);
      n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", stall); else n_pass++;
      n_total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got=%0b exp=0", mem_we); else n_pass++;
      n_total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata); else n_pass++;
      n_total++; if (rdata_valid !== 1'b0) $display("FAIL reset_rvalid got=%0b exp=0", rdata_valid); else n_pass++;
      n_total++; if (fault !== 1'b0) $display("FAIL reset_fault got=%0b exp=0", fault); else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_word();
      store_op(2'b10, 32'h10, 32'hDEAD_BEEF, s0, w0, f0, d0, a0, w1, s1, d1, a1);
      n_total++; if (w0 !== 1'b1) $display("FAIL sw_we got=%0b exp=1", w0); else n_pass++;
      n_total++; if (a0 !== 10'd4) $display("FAIL sw_addr got=%0d exp=4", a0); else n_pass++;
      n_total++; if (d0 !== 32'hDEAD_BEEF) $display("FAIL sw_wdata got=%h exp=deadbeef", d0); else n_pass++;
      n_total++; if (s0 !== 1'b0) $display("FAIL sw_stall got=%0b exp=0", s0); else n_pass++;
      n_total++; if (w1 !== 1'b0) $display("FAIL sw_we_pulse got=%0b exp=0", w1); else n_pass++;
      load_op(2'b10, 1'b0, 32'h10, s0, f0, v0, v1, d1, s1);
      n_total++; if (s0 !== 1'b1) $display("FAIL lw_stall0 got=%0b exp=1", s0); else n_pass++;
      n_total++; if (v0 !== 1'b0) $display("FAIL lw_valid0 got=%0b exp=0", v0); else n_pass++;
      n_total++; if (v1 !== 1'b1) $display("FAIL lw_valid1 got=%0b exp=1", v1); else n_pass++;
      n_total++; if (d1 !== 32'hDEAD_BEEF) $display("FAIL lw_rdata got=%h exp=deadbeef", d1); else n_pass++;
      n_total++; if (s1 !== 1'b0) $display("FAIL lw_stall1 got=%0b exp=0", s1); else n_pass++;
   endtask

   task automatic test_extension();
      store_op(2'b10, 32'h20, 32'h8070_F0A5, s0, w0, f0, d0, a0, w1, s1, d1, a1);
      load_op(2'b00, 1'b0, 32'h20, s0, f0, v0, v1, d1, s1);
      n_total++; if (d1 !== 32'hFFFF_FFA5) $display("FAIL lb got=%h exp=ffffffa5", d1); else n_pass++;
      load_op(2'b00, 1'b1, 32'h21, s0, f0, v0, v1, d1, s1);
      n_total++; if (d1 !== 32'h0000_00F0) $display("FAIL lbu got=%h exp=000000f0", d1); else n_pass++;
      load_op(2'b01, 1'b0, 32'h22, s0, f0, v0, v1, d1, s1);
      n_total++; if (d1 !== 32'hFFFF_8070) $display("FAIL lh got=%h exp=ffff8070", d1); else n_pass++;
      load_op(2'b01, 1'b1, 32'h22, s0, f0, v0, v1, d1, s1);
      n_total++; if (d1 !== 32'h0000_8070) $display("FAIL lhu got=%h exp=00008070", d1); else n_pass++;
      n_total++; if (v1 !== 1'b1) $display("FAIL lhu_valid got=%0b exp=1", v1); else n_pass++;
   endtask

   task automatic test_rmw();
      store_op(2'b10, 32'h30, 32'h1122_3344, s0, w0, f0, d0, a0, w1, s1, d1, a1);
      store_op(2'b00, 32'h31, 32'h1234_56AA, s0, w0, f0, d0, a0, w1, s1, d1, a1);
      n_total++; if (s0 !== 1'b1) $display("FAIL sb_stall0 got=%0b exp=1", s0); else n_pass++;
      n_total++; if (w0 !== 1'b0) $display("FAIL sb_we0 got=%0b exp=0", w0); else n_pass++;
      n_total++; if (w1 !== 1'b1) $display("FAIL sb_we1 got=%0b exp=1", w1); else n_pass++;
      n_total++; if (s1 !== 1'b0) $display("FAIL sb_stall1 got=%0b exp=0", s1); else n_pass++;
      n_total++; if (a1 !== 10'd12) $display("FAIL sb_addr got=%0d exp=12", a1); else n_pass++;
      n_total++; if (d1 !== 32'h1122_AA44) $display("FAIL sb_merge got=%h exp=1122aa44", d1); else n_pass++;
      store_op(2'b01, 32'h32, 32'h5555_BEEF, s0, w0, f0, d0, a0, w1, s1, d1, a1);
      n_total++; if (d1 !== 32'hBEEF_AA44) $display("FAIL sh_merge got=%h exp=beefaa44", d1); else n_pass++;
      n_total++; if (s0 !== 1'b1 || s1 !== 1'b0) $display("FAIL sh_stall got=%0b%0b exp=10", s0, s1); else n_pass++;
      @(negedge clk);
      n_total++; if (mem[12] !== 32'hBEEF_AA44) $display("FAIL rmw_mem got=%h exp=beefaa44", mem[12]); else n_pass++;
   endtask

   task automatic test_misalign();
      store_op(2'b10, 32'h40, 32'hCAFE_F00D, s0, w0, f0, d0, a0, w1, s1, d1, a1);
`ifdef LSU_MISALIGN_TRAP_EN
      load_op(2'b10, 1'b0, 32'h42, s0, f0, v0, v1, d1, s1);
      n_total++; if (f0 !== 1'b1) $display("FAIL lw_mis_fault got=%0b exp=1", f0); else n_pass++;
      n_total++; if (s0 !== 1'b0) $display("FAIL lw_mis_stall got=%0b exp=0", s0); else n_pass++;
      n_total++; if (v1 !== 1'b0) $display("FAIL lw_mis_valid got=%0b exp=0", v1); else n_pass++;
      wc = wr_cnt;
      store_op(2'b01, 32'h43, 32'h0000_1234, s0, w0, f0, d0, a0, w1, s1, d1, a1);
      n_total++; if (f0 !== 1'b1) $display("FAIL sh_mis_fault got=%0b exp=1", f0); else n_pass++;
      n_total++; if (w0 !== 1'b0 || w1 !== 1'b0) $display("FAIL sh_mis_we got=%0b%0b exp=00", w0, w1); else n_pass++;
      n_total++; if (s0 !== 1'b0) $display("FAIL sh_mis_stall got=%0b exp=0", s0); else n_pass++;
      n_total++; if (wr_cnt != wc) $display("FAIL sh_mis_writes got=%0d exp=%0d", wr_cnt, wc); else n_pass++;
      n_total++; if (mem[16] !== 32'hCAFE_F00D) $display("FAIL sh_mis_mem got=%h exp=cafef00d", mem[16]); else n_pass++;
`else
      load_op(2'b10, 1'b0, 32'h42, s0, f0, v0, v1, d1, s1);
      n_total++; if (f0 !== 1'b0) $display("FAIL lw_mis_fault got=%0b exp=0", f0); else n_pass++;
      n_total++; if (s0 !== 1'b1) $display("FAIL lw_mis_stall got=%0b exp=1", s0); else n_pass++;
      n_total++; if (d1 !== 32'hCAFE_F00D) $display("FAIL lw_mis_rdata got=%h exp=cafef00d", d1); else n_pass++;
      store_op(2'b01, 32'h43, 32'h0000_1234, s0, w0, f0, d0, a0, w1, s1, d1, a1);
      n_total++; if (f0 !== 1'b0) $display("FAIL sh_mis_fault got=%0b exp=0", f0); else n_pass++;
      n_total++; if (d1 !== 32'h1234_F00D) $display("FAIL sh_mis_merge got=%h exp=1234f00d", d1); else n_pass++;
      load_op(2'b11, 1'b0, 32'h41, s0, f0, v0, v1, d1, s1);
      n_total++; if (d1 !== 32'h1234_F00D) $display("FAIL sz11_rdata got=%h exp=1234f00d", d1); else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      store_op(2'b10, 32'h50, 32'h0102_0304, s0, w0, f0, d0, a0, w1, s1, d1, a1);
      wc = wr_cnt;
      store_op(2'b00, 32'h52, 32'h0000_00EE, s0, w0, f0, d0, a0, w1, s1, d1, a1);
      load_op(2'b10, 1'b0, 32'h50, s0, f0, v0, v1, d1, s1);
      n_total++; if (s0 !== 1'b1) $display("FAIL b2b_accept got=%0b exp=1", s0); else n_pass++;
      n_total++; if (d1 !== 32'h01EE_0304) $display("FAIL b2b_rdata got=%h exp=01ee0304", d1); else n_pass++;
      n_total++; if (wr_cnt != wc + 1) $display("FAIL b2b_writes got=%0d exp=%0d", wr_cnt, wc + 1); else n_pass++;
   endtask

   task automatic test_reset_mid_rmw();
      store_op(2'b10, 32'h60, 32'h1234_5678, s0, w0, f0, d0, a0, w1, s1, d1, a1);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 32'h62; req_wdata = 32'hABCD;
      @(negedge clk);
      n_total++; if (stall !== 1'b1) $display("FAIL rst_rmw_stall0 got=%0b exp=1", stall); else n_pass++;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0;
      #1;
      n_total++; if (mem_we !== 1'b1) $display("FAIL rst_rmw_pending got=%0b exp=1", mem_we); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if (mem_we !== 1'b0) $display("FAIL rst_rmw_we got=%0b exp=0", mem_we); else n_pass++;
      n_total++; if (stall !== 1'b0) $display("FAIL rst_rmw_stall got=%0b exp=0", stall); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_total++; if (mem[24] !== 32'h1234_5678) $display("FAIL rst_rmw_mem got=%h exp=12345678", mem[24]); else n_pass++;
      load_op(2'b10, 1'b0, 32'h60, s0, f0, v0, v1, d1, s1);
      n_total++; if (s0 !== 1'b1 || d1 !== 32'h1234_5678) $display("FAIL rst_rmw_idle got=%0b/%h exp=1/12345678", s0, d1); else n_pass++;
   endtask

   initial begin
      #12;
      test_reset();
      test_word();
      test_extension();
      test_rmw();
      test_misalign();
      test_back_to_back();
      test_reset_mid_rmw();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
